// File: rtl/crc8.sv
// Serial CRC-8 generator/checker: one message bit per enabled clock, MSB-first,
// no reflection, no final XOR. Register is exposed directly as the CRC output.
module crc8 #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h07,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             enable,
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q, crc_d;
  logic             fb;

  // din only enters the datapath under enable, so X on an idle din never reaches the flops
  always_comb begin
    fb    = 1'b0;
    crc_d = crc_q;
    if (enable) begin
      fb    = din ^ crc_q[WIDTH-1];
      crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: tb/tb_crc8.sv
// Randomized and directed bench for crc8; model computes the CRC by polynomial
// long division of the bits fed since the last reset.
module tb_crc8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       din = 1'b0;
  logic [7:0] crc;

  int n_cmp = 0;
  int n_err = 0;

  bit msg_q[$];
  bit model_valid = 1'b0;

  crc8 dut (
    .enable (enable),
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .crc    (crc)
  );

  always #5 clk = ~clk;

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, computed on an explicit bit array.
  function automatic logic [7:0] model_crc();
    bit       work[$];
    bit [8:0] poly;
    logic [7:0] rem;
    poly = 9'h107;
    work = msg_q;
    for (int k = 0; k < 8; k++) work.push_back(1'b0);
    for (int i = 0; i + 8 < work.size(); i++) begin
      if (work[i]) begin
        for (int j = 0; j < 9; j++) work[i+j] = work[i+j] ^ poly[8-j];
      end
    end
    for (int k = 0; k < 8; k++) rem[7-k] = work[work.size()-8+k];
    return rem;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      msg_q.delete();
      model_valid = 1'b1;
    end else if (enable) begin
      msg_q.push_back(din);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_crc;
    if (model_valid) begin
      exp_crc = model_crc();
      n_cmp++;
      if (crc !== exp_crc) begin
        n_err++;
        $display("FAIL model_cycle @%0t: crc=%02h expected=%02h", $time, crc, exp_crc);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got=%02h expected=%02h", name, got, exp_v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic en, input logic d);
    reset  = 1'b1;
    enable = en;
    din    = d;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic feed_bit(input logic b, input int gap_max);
    enable = 1'b1;
    din    = b;
    @(posedge clk);
    #1;
    enable = 1'b0;
    if (gap_max > 0) idle($urandom_range(0, gap_max));
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap_max);
    for (int i = 7; i >= 0; i--) feed_bit(b[i], gap_max);
  endtask

  task automatic feed_check_str(input int gap_max);
    logic [7:0] s;
    for (int c = 0; c < 9; c++) begin
      s = 8'h31 + 8'(c);
      feed_byte(s, gap_max);
    end
  endtask

  initial begin
    logic [7:0] a5;
    int len;
    #2;

    // Reset beats enable and din
    do_reset(1'b1, 1'b1);
    chk("reset_value", crc, 8'h00);
    idle(10);
    chk("reset_hold", crc, 8'h00);

    do_reset(1'b0, 1'b0);
    feed_byte(8'h01, 0);
    chk("byte_01", crc, 8'h07);
    do_reset(1'b0, 1'b0);
    feed_byte(8'h80, 0);
    chk("byte_80", crc, 8'h89);
    chk("model_pin_80", model_crc(), 8'h89);

    do_reset(1'b0, 1'b0);
    feed_check_str(0);
    chk("check_123456789", crc, 8'hF4);
    chk("model_pin_check", model_crc(), 8'hF4);
    do_reset(1'b0, 1'b0);
    feed_check_str(5);
    chk("check_gapped", crc, 8'hF4);

    do_reset(1'b0, 1'b0);
    feed_byte(8'h01, 0);
    feed_byte(8'h07, 0);
    chk("residue_zero", crc, 8'h00);
    // Flipping the LSB of the trailer leaves the CRC of a lone trailing 1 bit: x^8 mod P
    do_reset(1'b0, 1'b0);
    feed_byte(8'h01, 0);
    feed_byte(8'h06, 0);
    chk("residue_flipped", crc, 8'h07);

    do_reset(1'b0, 1'b0);
    a5 = 8'hA5;
    for (int i = 7; i >= 4; i--) feed_bit(a5[i], 0);
    do_reset(1'b1, 1'b1);
    chk("mid_reset_init", crc, 8'h00);
    feed_byte(8'h01, 0);
    chk("mid_reset_restart", crc, 8'h07);

    // Hold with toggling and unknown din
    for (int i = 0; i < 16; i++) begin
      enable = 1'b0;
      din    = (i % 3 == 2) ? 1'bx : 1'(i & 1);
      @(posedge clk);
      #1;
      chk("hold", crc, 8'h07);
    end
    din = 1'b0;

    // Random messages, gaps and occasional resets; checked each cycle against the model
    for (int m = 0; m < 12; m++) begin
      if ($urandom_range(0, 2) != 0) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      len = $urandom_range(1, 48);
      for (int i = 0; i < len; i++) begin
        feed_bit(1'($urandom_range(0, 1)), 3);
        if ($urandom_range(0, 60) == 0) do_reset(1'b1, 1'($urandom_range(0, 1)));
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
